skinny_round_ctrl: RTL

Round scheduler for the masked SKINNY-128 datapath on 6 Series. Sequences load, masked SubCells, and the linear layer (AddConstants/AddRoundTweakey/MSKShiftRows/MixColumns) for ROUNDS rounds. Generates the 6-bit round-constant LFSR and stalls the masked S-box pipeline whenever fresh randomness is not available.

---
 rtl/skinny_round_ctrl_if.sv | 24 ++
 rtl/skinny_round_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/skinny_round_ctrl_if.sv
// Control bundle between the SKINNY round scheduler (slave) and the block driving it (master).
interface skinny_round_ctrl_if;
  logic       start;
  logic       rnd_valid;
  logic       busy;
  logic       done;
  logic       ld_state;
  logic       sb_en;
  logic       rnd_req;
  logic       lin_en;
  logic [5:0] rc;
  logic [5:0] round;
  logic       last_round;

  modport master (
    output start, rnd_valid,
    input  busy, done, ld_state, sb_en, rnd_req, lin_en, rc, round, last_round
  );

  modport slave (
    input  start, rnd_valid,
    output busy, done, ld_state, sb_en, rnd_req, lin_en, rc, round, last_round
  );
endinterface

// File: rtl/skinny_round_ctrl.sv
// Round scheduler for the masked SKINNY-128 datapath: load, masked SubCells with
// randomness stalls, linear layer, and the 6-bit round-constant LFSR.
//
// state | meaning
// IDLE  | waiting for start; round and rc parked at 0
// LOAD  | plaintext/tweakey load into datapath registers (1 cycle)
// SBOX  | masked S-box pipeline advances only when fresh randomness is present
// LIN   | linear layer registered, tweakey schedule stepped (1 cycle)
// DONE  | ciphertext valid pulse (1 cycle)
module skinny_round_ctrl #(
  parameter int d        = 2,
  parameter int ROUNDS   = 40,
  parameter int SBOX_LAT = 4
) (
  input logic                clk,
  input logic                rst_n,
  skinny_round_ctrl_if.slave bus
);

  localparam int CW = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SBOX_LAT - 1);
  localparam logic [5:0]    ROUND_MAX = 6'(ROUNDS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SBOX = 3'd2;
  localparam logic [2:0] S_LIN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Share count only matters to the datapath; it is range-checked here.
  if (d < 1 || ROUNDS < 1 || ROUNDS > 63 || SBOX_LAT < 1) begin : g_bad_param
    $error("skinny_round_ctrl: parameter out of range");
  end

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [5:0]    round_q;
  logic [5:0]    rc_q;

  function automatic logic [5:0] lfsr_next(input logic [5:0] v);
    return {v[4:0], ~(v[5] ^ v[4])};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      round_q <= '0;
      rc_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt     <= '0;
          round_q <= '0;
          rc_q    <= '0;
          if (bus.start) state <= S_LOAD;
        end
        S_LOAD: begin
          state   <= S_SBOX;
          cnt     <= '0;
          round_q <= 6'd1;
          rc_q    <= lfsr_next(6'h00);
        end
        S_SBOX: begin
          // Without fresh masks the pipeline freezes; there is deliberately no timeout.
          if (bus.rnd_valid) begin
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= S_LIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_LIN: begin
          if (round_q == ROUND_MAX) begin
            state <= S_DONE;
          end else begin
            state   <= S_SBOX;
            round_q <= round_q + 6'd1;
            rc_q    <= lfsr_next(rc_q);
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          round_q <= '0;
          rc_q    <= '0;
        end
        default: begin
          state   <= S_IDLE;
          cnt     <= '0;
          round_q <= '0;
          rc_q    <= '0;
        end
      endcase
    end
  end

  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = (state == S_DONE);
  assign bus.ld_state   = (state == S_LOAD);
  assign bus.rnd_req    = (state == S_SBOX);
  assign bus.sb_en      = (state == S_SBOX) & bus.rnd_valid;
  assign bus.lin_en     = (state == S_LIN);
  assign bus.rc         = rc_q;
  assign bus.round      = round_q;
  assign bus.last_round = (round_q == ROUND_MAX);

endmodule
